// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a show-ahead FIFO: pops one word per frame and
// shifts it out LSB first, framed by a start bit and STOP_BITS stop bits.
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CLKS   = 10417,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic                  tx_en,
  output logic                  rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done_tick
);

  localparam int CLK_W = $clog2(BIT_CLKS);
  localparam int BIT_N = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
  localparam int BIT_W = (BIT_N > 1) ? $clog2(BIT_N) : 1;

  localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(BIT_CLKS - 1);
  localparam logic [CLK_W-1:0] CLK_PEN   = CLK_W'(BIT_CLKS - 2);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state_q, state_d;
  logic [CLK_W-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   sreg_q, sreg_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    bit_end;

  // Pop strobe stays combinational so the FIFO advances in the same cycle
  // the head word is captured; reset masks it so no word is lost silently.
  assign rd      = (state_q == IDLE) && !empty && tx_en && !reset;
  assign bit_end = (clk_cnt_q == CLK_LAST);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sreg_d    = sreg_q;
    tx_d      = tx_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (rd) begin
          sreg_d    = r_data;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          tx_d      = sreg_q[0];
          sreg_d    = sreg_q >> 1;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            tx_d      = 1'b1;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            tx_d      = sreg_q[0];
            sreg_d    = sreg_q >> 1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      STOP: begin
        // Registered tick: raise it one cycle early so it lands on the last stop cycle.
        done_d = (bit_cnt_q == STOP_LAST) && (clk_cnt_q == CLK_PEN);
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      sreg_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sreg_q    <= sreg_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx           = tx_q;
  assign busy         = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per frame payload.
REQ-002 SHALL have parameter BIT_CLKS, default 10417, meaning clk cycles per serial bit (legal: >=2).
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal: 1 or 2).
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port empty  input  1  upstream FIFO empty flag.
REQ-007 SHALL have port r_data  input  DATA_WIDTH  FIFO head word, valid whenever empty=0 (show-ahead).
REQ-008 SHALL have port tx_en  input  1  permits starting new frames.
REQ-009 SHALL have port rd  output  1  FIFO pop strobe, combinational, one cycle per word.
REQ-010 SHALL have port tx  output  1  serial line, registered, idle high.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have port tx_done_tick  output  1  one-cycle pulse at frame completion.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, with a clock counter (0..BIT_CLKS-1) and a bit counter.
REQ-014 SHALL assert rd only in IDLE with empty=0 and tx_en=1; in that cycle the FSM latches r_data into the shift register, clears both counters, and moves to START.
REQ-015 SHALL never assert rd while empty=1, outside IDLE, or for more than one consecutive cycle.
REQ-016 SHALL timing: for rd in cycle t, tx=0 in cycles t+1..t+BIT_CLKS (start bit).
REQ-017 SHALL send data LSB first; bit i drives tx in cycles t+1+(1+i)*BIT_CLKS .. t+(2+i)*BIT_CLKS.
REQ-018 SHALL drive tx=1 for STOP_BITS*BIT_CLKS cycles after the last data bit.
REQ-019 SHALL pulse tx_done_tick in the final STOP cycle, cycle t+(1+DATA_WIDTH+STOP_BITS)*BIT_CLKS, then enter IDLE.
REQ-020 SHALL, with FIFO non-empty and tx_en=1, issue the next rd in the first IDLE cycle; back-to-back rd spacing is exactly (1+DATA_WIDTH+STOP_BITS)*BIT_CLKS+1 cycles.
REQ-021 SHALL hold tx=1 in IDLE.
REQ-022 SHALL make busy=1 from cycle t+1 through the tx_done_tick cycle inclusive.
REQ-023 SHALL treat tx_en deassertion mid-frame as gating new frames only; the current frame completes unchanged.
REQ-024 SHALL ignore changes on r_data and empty while not in IDLE.
REQ-025 SHALL size counters with $clog2 of their maximum value, with no wrap-around except the explicit clear at each bit boundary.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, force state=IDLE, tx=1, busy=0, rd=0, tx_done_tick=0, and counters and shift register to 0.
REQ-027 SHALL make reset take priority over every transition, including a pop in the same cycle; rd SHALL be 0 during any cycle with reset=1.
REQ-028 SHALL abort any frame in progress on reset, with tx high from the next cycle; the already-popped word is discarded, not retried.

Verification
(Bench configuration: DATA_WIDTH=8, BIT_CLKS=4, STOP_BITS=1 unless noted.)
REQ-029 SHALL verify single word: FIFO holds 0xA5, tx_en=1 -> one rd pulse; tx per 4-cycle slot = 0,1,0,1,0,0,1,0,1,1; tx_done_tick at rd+40; busy high for 40 cycles.
REQ-030 SHALL verify back-to-back: FIFO holds 0x00 and 0xFF -> rd pulses exactly 41 cycles apart; second frame is 0 followed by 8 ones then stop; no third rd once empty=1.
REQ-031 SHALL verify empty and gating: empty=1 for 100 cycles -> rd=0 and tx=1 throughout; non-empty with tx_en=0 -> no rd; raising tx_en -> rd in the same cycle.
REQ-032 SHALL verify tx_en drop mid-frame: deassert tx_en at rd+10 -> frame completes bit-exact; no further rd while tx_en=0.
REQ-033 SHALL verify reset mid-frame: reset at rd+15 for one cycle -> tx=1, busy=0 next cycle; a new rd occurs in the first cycle after reset if empty=0.
REQ-034 SHALL verify STOP_BITS=2: byte 0x3C -> stop high for 8 cycles; tx_done_tick at rd+44; rd spacing 45 cycles.
